riscv_wb_scoreboard: RTL and testbench
======================================

# riscv_wb_scoreboard

Register-file hazard scoreboard and write-port sequencer for the in-order RISC-V pipeline. It tracks every in-flight instruction that will write `riscv_regfile`. It stalls issue while a source register still has a write pending. It drives the regfile write address and enable at the fixed writeback latency, so the regfile never returns stale data to the decode stage.

## Interface
Parameters:
- `WB_LAT`, default 3: cycles from issue acceptance to regfile write (≥1).
- `CNT_W`, default `$clog2(WB_LAT+1)`: width of each per-register pending counter.

Ports:
- `clk_i` in 1: single clock, all state on its rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `issue_valid_i` in 1: decode presents an instruction.
- `issue_ready_o` out 1: instruction accepted this cycle when high together with `issue_valid_i`.
- `issue_rs1_i` in 5, `issue_rs2_i` in 5: source register addresses.
- `issue_rs1_use_i` in 1, `issue_rs2_use_i` in 1: the source is actually read.
- `issue_rd_i` in 5: destination register address.
- `issue_rd_we_i` in 1: the instruction writes `rd`.
- `flush_i` in 1: kill all in-flight entries that are not committing this cycle.
- `regwen_o` out 1: regfile write enable, to `RegWEn_i`.
- `wb_addr_o` out 5: regfile write address, to `AddrD_i`.
- `stall_o` out 1: hazard stall, equal to `issue_valid_i && !issue_ready_o`.
- `busy_o` out 32: bit r is high while register r has ≥1 pending write.
- `inflight_o` out CNT_W: number of valid entries in the writeback shift line.
- `stall_cnt_o` out 32: saturating count of stall cycles.

## Operation
- **Shift line.** `WB_LAT` stages, each holding {valid, rd}. It advances every cycle unconditionally. Stage 0 loads {accept && rd_we && rd≠0, rd}. The last stage is the commit stage.
- **Commit.** `regwen_o` = commit-stage valid and `wb_addr_o` = commit-stage rd. When `regwen_o` is low, `wb_addr_o` holds the last committed rd.
- **Pending counters.** One `CNT_W`-bit counter per register, r = 1..31. Register 0 has none and `busy_o[0]` = 0 always.
  - +1 on accept with rd_we, rd = r, rd ≠ 0.
  - −1 on commit of r.
  - Both in the same cycle: unchanged.
  - The maximum count is `WB_LAT` by construction. Overflow and underflow are design errors; add assertions for both.
- **`busy_o[r]`** = (count[r] ≠ 0).
- **Hazard.** `issue_ready_o` = !((rs1_use && rs1≠0 && busy[rs1]) || (rs2_use && rs2≠0 && busy[rs2])).
  - `issue_ready_o` is combinational from current state and inputs.
  - There is no WAW check; fixed latency keeps writes ordered.
- **Accept** = `issue_valid_i && issue_ready_o && !flush_i`. An issue presented during `flush_i` is dropped.
- **Flush.**
  - All stages except the commit stage become invalid at the next edge.
  - The commit stage's write still happens this cycle.
  - All counters clear to 0.
- **`inflight_o`** = popcount of valid stages.
- **`stall_cnt_o`** increments on every cycle with `stall_o` high and saturates at 0xFFFFFFFF.

## Timing
- **Reset values** (asynchronous, immediate on `rst_i`):
  - all stages invalid, all counters 0
  - `regwen_o`=0, `wb_addr_o`=0, `busy_o`=0, `inflight_o`=0, `stall_cnt_o`=0
  - `issue_ready_o`=1, `stall_o`=0
- **Reset mid-operation** discards all pending writes. No `regwen_o` pulse follows the release of reset.
- **Latency.** An instruction accepted at edge N has `regwen_o` high during cycle N+`WB_LAT`. The regfile write occurs at the end of that cycle.
- **Busy window.**
  - `busy_o[rd]` rises in cycle N+1.
  - It stays high through the commit cycle.
  - It falls in cycle N+`WB_LAT`+1, unless another write to rd is still pending.
- **Read-after-write spacing.** The regfile reads synchronously and returns the old value on a same-edge read/write. A dependent instruction is therefore accepted no earlier than cycle N+`WB_LAT`+1.
- **Same-register accept and commit in one cycle:** the counter is unchanged and `busy_o` stays high.
- **Self-dependency** (rs1 = rd, not busy): accepted, and rd becomes busy from the next cycle.
- **Back-to-back independent issues** are accepted every cycle with no bubbles.

## Test plan
- **Reset and idle.** Assert `rst_i` asynchronously mid-cycle → all outputs reach their reset values immediately. Deassert, then issue x5 write with no sources → accepted.
- **RAW stall (`WB_LAT`=3).** Issue x5 write at cycle 0, then issue rs1=x5 from cycle 1 onward.
  - `stall_o` high in cycles 1–3.
  - `regwen_o`=1 with `wb_addr_o`=5 in cycle 3.
  - Accepted in cycle 4.
  - `stall_cnt_o`=3.
- **x0 handling.** Issue rd=x0 with we=1, then rs1=x0 → `regwen_o` never asserts, `busy_o`=0, no stall.
- **Overlapping writes.** Write x7 in cycles 0, 1, 2 → count[7] reaches 3. `regwen_o` for x7 in cycles 3, 4, 5. `busy_o[7]` falls in cycle 6.
- **Flush.** Write x3, x4, x6 in cycles 0–2, then `flush_i` in cycle 3 with a valid issue.
  - x3 commits in cycle 3.
  - x4 and x6 never commit.
  - `busy_o`=0 and `inflight_o`=0 from cycle 4.
  - The cycle-3 issue is dropped.
- **Throughput.** 100 random independent issues → zero stalls. `regwen_o` sequence equals the issued rd≠0 sequence delayed by exactly 3 cycles.

Source files
------------

// File: rtl/riscv_wb_scoreboard_if.sv
// Issue/writeback bundle between decode, the hazard scoreboard and the regfile write port.
// The _i/_o suffixes are named from the scoreboard's point of view.
interface riscv_wb_scoreboard_if #(
  parameter int CNT_W = 2
);
  logic             issue_valid_i;
  logic             issue_ready_o;
  logic [4:0]       issue_rs1_i;
  logic [4:0]       issue_rs2_i;
  logic             issue_rs1_use_i;
  logic             issue_rs2_use_i;
  logic [4:0]       issue_rd_i;
  logic             issue_rd_we_i;
  logic             flush_i;
  logic             regwen_o;
  logic [4:0]       wb_addr_o;
  logic             stall_o;
  logic [31:0]      busy_o;
  logic [CNT_W-1:0] inflight_o;
  logic [31:0]      stall_cnt_o;

  modport master (
    output issue_valid_i, issue_rs1_i, issue_rs2_i, issue_rs1_use_i, issue_rs2_use_i,
           issue_rd_i, issue_rd_we_i, flush_i,
    input  issue_ready_o, regwen_o, wb_addr_o, stall_o, busy_o, inflight_o, stall_cnt_o
  );

  modport slave (
    input  issue_valid_i, issue_rs1_i, issue_rs2_i, issue_rs1_use_i, issue_rs2_use_i,
           issue_rd_i, issue_rd_we_i, flush_i,
    output issue_ready_o, regwen_o, wb_addr_o, stall_o, busy_o, inflight_o, stall_cnt_o
  );
endinterface

// File: rtl/riscv_wb_scoreboard.sv
// Regfile hazard scoreboard: fixed-latency writeback shift line, per-register pending
// counters, RAW stall generation and a saturating stall counter.
module riscv_wb_scoreboard #(
  parameter int WB_LAT = 3,
  parameter int CNT_W  = $clog2(WB_LAT+1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  riscv_wb_scoreboard_if.slave sb
);
  localparam int LAST = WB_LAT - 1;

  logic [WB_LAT-1:0]      vld_pipe_q, vld_pipe_d;
  logic [WB_LAT-1:0][4:0] rd_pipe_q, rd_pipe_d;
  logic [31:1][CNT_W-1:0] cnt_q, cnt_d;
  logic [31:1]            inc, dec;
  logic [4:0]             last_addr_q, last_addr_d;
  logic [31:0]            stall_cnt_q, stall_cnt_d;
  logic [31:0]            busy;
  logic [CNT_W-1:0]       inflight;
  logic                   ready, stall, accept, alloc, commit;
  logic [4:0]             commit_rd;

  assign commit    = vld_pipe_q[LAST];
  assign commit_rd = rd_pipe_q[LAST];

  always_comb begin
    busy = '0;
    for (int r = 1; r < 32; r++) busy[r] = |cnt_q[r];
  end

  // x0 never has a pending write, so it needs no explicit exclusion beyond busy[0]=0.
  assign ready  = !((sb.issue_rs1_use_i && sb.issue_rs1_i != 5'd0 && busy[sb.issue_rs1_i]) ||
                    (sb.issue_rs2_use_i && sb.issue_rs2_i != 5'd0 && busy[sb.issue_rs2_i]));
  assign stall  = sb.issue_valid_i && !ready;
  assign accept = sb.issue_valid_i && ready && !sb.flush_i;
  assign alloc  = accept && sb.issue_rd_we_i && sb.issue_rd_i != 5'd0;

  // Flush only kills younger stages; the commit stage leaves the line this edge anyway.
  always_comb begin
    vld_pipe_d    = '0;
    rd_pipe_d     = rd_pipe_q;
    vld_pipe_d[0] = alloc;
    rd_pipe_d[0]  = sb.issue_rd_i;
    for (int i = 1; i < WB_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1] && !sb.flush_i;
      rd_pipe_d[i]  = rd_pipe_q[i-1];
    end
  end

  always_comb begin
    inc   = '0;
    dec   = '0;
    cnt_d = cnt_q;
    for (int r = 1; r < 32; r++) begin
      inc[r] = alloc  && sb.issue_rd_i == 5'(r);
      dec[r] = commit && commit_rd     == 5'(r);
      if (sb.flush_i)              cnt_d[r] = '0;
      else if (inc[r] && !dec[r])  cnt_d[r] = cnt_q[r] + CNT_W'(1);
      else if (dec[r] && !inc[r])  cnt_d[r] = cnt_q[r] - CNT_W'(1);
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < WB_LAT; i++) inflight = inflight + CNT_W'(vld_pipe_q[i]);
  end

  assign last_addr_d = commit ? commit_rd : last_addr_q;
  assign stall_cnt_d = stall_cnt_q + {31'd0, stall && !(&stall_cnt_q)};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe_q  <= '0;
      rd_pipe_q   <= '0;
      cnt_q       <= '0;
      last_addr_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      rd_pipe_q   <= rd_pipe_d;
      cnt_q       <= cnt_d;
      last_addr_q <= last_addr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sb.issue_ready_o = ready;
  assign sb.stall_o       = stall;
  assign sb.regwen_o      = commit;
  assign sb.wb_addr_o     = last_addr_d;
  assign sb.busy_o        = busy;
  assign sb.inflight_o    = inflight;
  assign sb.stall_cnt_o   = stall_cnt_q;

  // A register can have at most WB_LAT writes in flight; anything else is a tracking bug.
  for (genvar r = 1; r < 32; r++) begin : g_cnt_chk
    assert property (@(posedge clk_i) disable iff (rst_i)
      !(inc[r] && !dec[r] && !sb.flush_i && cnt_q[r] == CNT_W'(WB_LAT)));
    assert property (@(posedge clk_i) disable iff (rst_i)
      !(dec[r] && !inc[r] && !sb.flush_i && cnt_q[r] == '0));
  end
endmodule

// File: tb/tb_riscv_wb_scoreboard.sv
// Directed bench for riscv_wb_scoreboard (WB_LAT=3): reset, RAW stall, x0, overlap,
// flush, same-register accept/commit and back-to-back throughput.
module tb_riscv_wb_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  riscv_wb_scoreboard_if #(.CNT_W(2)) sb ();
  riscv_wb_scoreboard #(.WB_LAT(3), .CNT_W(2)) dut (.clk_i(clk), .rst_i(rst), .sb(sb));

  task automatic idle();
    sb.issue_valid_i   = 1'b0;
    sb.issue_rs1_i     = 5'd0;
    sb.issue_rs2_i     = 5'd0;
    sb.issue_rs1_use_i = 1'b0;
    sb.issue_rs2_use_i = 1'b0;
    sb.issue_rd_i      = 5'd0;
    sb.issue_rd_we_i   = 1'b0;
    sb.flush_i         = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic we, input logic [4:0] rs1, input logic u1);
    idle();
    sb.issue_valid_i   = 1'b1;
    sb.issue_rd_i      = rd;
    sb.issue_rd_we_i   = we;
    sb.issue_rs1_i     = rs1;
    sb.issue_rs1_use_i = u1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue(5'd5, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (sb.issue_ready_o !== 1'b1) begin errors++; $display("FAIL rst_first_ready got %b want 1", sb.issue_ready_o); end
    tick();
    issue(5'd0, 1'b0, 5'd5, 1'b1);
    @(negedge clk);
    checks++; if (sb.stall_o !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got %b want 1", sb.stall_o); end
    checks++; if (sb.busy_o !== 32'h20) begin errors++; $display("FAIL rst_pre_busy got %h want 00000020", sb.busy_o); end
    tick();
    checks++; if (sb.stall_cnt_o !== 32'd1) begin errors++; $display("FAIL rst_pre_stallcnt got %0d want 1", sb.stall_cnt_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (sb.regwen_o !== 1'b0) begin errors++; $display("FAIL rst_regwen got %b want 0", sb.regwen_o); end
    checks++; if (sb.wb_addr_o !== 5'd0) begin errors++; $display("FAIL rst_wb_addr got %0d want 0", sb.wb_addr_o); end
    checks++; if (sb.busy_o !== 32'h0) begin errors++; $display("FAIL rst_busy got %h want 0", sb.busy_o); end
    checks++; if (sb.inflight_o !== 2'd0) begin errors++; $display("FAIL rst_inflight got %0d want 0", sb.inflight_o); end
    checks++; if (sb.stall_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_stallcnt got %0d want 0", sb.stall_cnt_o); end
    checks++; if (sb.issue_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", sb.issue_ready_o); end
    checks++; if (sb.stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", sb.stall_o); end
    tick();
    idle();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (sb.regwen_o !== 1'b0) begin errors++; $display("FAIL rst_post_regwen cyc %0d got %b want 0", c, sb.regwen_o); end
      tick();
    end
    issue(5'd5, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (sb.issue_ready_o !== 1'b1) begin errors++; $display("FAIL rst_idle_ready got %b want 1", sb.issue_ready_o); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (sb.busy_o !== 32'h20) begin errors++; $display("FAIL rst_idle_busy got %h want 00000020", sb.busy_o); end
    repeat (4) tick();
  endtask

  task automatic test_raw();
    do_reset();
    issue(5'd5, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (sb.issue_ready_o !== 1'b1) begin errors++; $display("FAIL raw_c0_ready got %b want 1", sb.issue_ready_o); end
    tick();
    for (int c = 1; c <= 4; c++) begin
      issue(5'd9, 1'b1, 5'd5, 1'b1);
      @(negedge clk);
      checks++; if (sb.stall_o !== (c <= 3)) begin errors++; $display("FAIL raw_stall cyc %0d got %b want %b", c, sb.stall_o, c <= 3); end
      checks++; if (sb.regwen_o !== (c == 3)) begin errors++; $display("FAIL raw_regwen cyc %0d got %b want %b", c, sb.regwen_o, c == 3); end
      if (c == 3) begin
        checks++; if (sb.wb_addr_o !== 5'd5) begin errors++; $display("FAIL raw_wb_addr got %0d want 5", sb.wb_addr_o); end
      end
      if (c == 4) begin
        checks++; if (sb.issue_ready_o !== 1'b1) begin errors++; $display("FAIL raw_accept got %b want 1", sb.issue_ready_o); end
        checks++; if (sb.stall_cnt_o !== 32'd3) begin errors++; $display("FAIL raw_stallcnt got %0d want 3", sb.stall_cnt_o); end
        checks++; if (sb.busy_o !== 32'h0) begin errors++; $display("FAIL raw_busy_c4 got %h want 0", sb.busy_o); end
      end
      tick();
    end
    idle();
    @(negedge clk);
    checks++; if (sb.wb_addr_o !== 5'd5 || sb.regwen_o !== 1'b0) begin errors++; $display("FAIL raw_hold got addr %0d we %b want 5/0", sb.wb_addr_o, sb.regwen_o); end
    checks++; if (sb.busy_o !== 32'h200) begin errors++; $display("FAIL raw_dep_busy got %h want 00000200", sb.busy_o); end
    tick();
    tick();
    @(negedge clk);
    checks++; if (sb.regwen_o !== 1'b1 || sb.wb_addr_o !== 5'd9) begin errors++; $display("FAIL raw_dep_commit got we %b addr %0d want 1/9", sb.regwen_o, sb.wb_addr_o); end
    repeat (2) tick();
  endtask

  task automatic test_x0();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c == 0) issue(5'd0, 1'b1, 5'd0, 1'b0);
      else if (c == 1) issue(5'd0, 1'b1, 5'd0, 1'b1);
      else idle();
      @(negedge clk);
      checks++; if (sb.regwen_o !== 1'b0) begin errors++; $display("FAIL x0_regwen cyc %0d got %b want 0", c, sb.regwen_o); end
      checks++; if (sb.busy_o !== 32'h0) begin errors++; $display("FAIL x0_busy cyc %0d got %h want 0", c, sb.busy_o); end
      checks++; if (sb.stall_o !== 1'b0) begin errors++; $display("FAIL x0_stall cyc %0d got %b want 0", c, sb.stall_o); end
      checks++; if (sb.inflight_o !== 2'd0) begin errors++; $display("FAIL x0_inflight cyc %0d got %0d want 0", c, sb.inflight_o); end
      tick();
    end
  endtask

  task automatic test_overlap();
    logic [7:0] exp_we;
    logic [7:0] exp_busy;
    int exp_inf [8];
    exp_we   = 8'b0011_1000;
    exp_busy = 8'b0011_1110;
    exp_inf  = '{0, 1, 2, 3, 2, 1, 0, 0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 3) issue(5'd7, 1'b1, 5'd0, 1'b0);
      else idle();
      @(negedge clk);
      if (c < 3) begin
        checks++; if (sb.issue_ready_o !== 1'b1) begin errors++; $display("FAIL ovl_ready cyc %0d got %b want 1", c, sb.issue_ready_o); end
      end
      checks++; if (sb.regwen_o !== exp_we[c]) begin errors++; $display("FAIL ovl_regwen cyc %0d got %b want %b", c, sb.regwen_o, exp_we[c]); end
      if (exp_we[c]) begin
        checks++; if (sb.wb_addr_o !== 5'd7) begin errors++; $display("FAIL ovl_addr cyc %0d got %0d want 7", c, sb.wb_addr_o); end
      end
      checks++; if (sb.busy_o[7] !== exp_busy[c]) begin errors++; $display("FAIL ovl_busy7 cyc %0d got %b want %b", c, sb.busy_o[7], exp_busy[c]); end
      checks++; if (int'(sb.inflight_o) != exp_inf[c]) begin errors++; $display("FAIL ovl_inflight cyc %0d got %0d want %0d", c, sb.inflight_o, exp_inf[c]); end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c == 0) issue(5'd3, 1'b1, 5'd0, 1'b0);
      if (c == 1) issue(5'd4, 1'b1, 5'd0, 1'b0);
      if (c == 2) issue(5'd6, 1'b1, 5'd0, 1'b0);
      if (c == 3) begin
        issue(5'd8, 1'b1, 5'd0, 1'b0);
        sb.flush_i = 1'b1;
      end
      @(negedge clk);
      if (c == 3) begin
        checks++; if (sb.regwen_o !== 1'b1 || sb.wb_addr_o !== 5'd3) begin errors++; $display("FAIL fl_commit got we %b addr %0d want 1/3", sb.regwen_o, sb.wb_addr_o); end
        checks++; if (sb.busy_o !== 32'h58) begin errors++; $display("FAIL fl_busy_c3 got %h want 00000058", sb.busy_o); end
      end
      if (c >= 4) begin
        checks++; if (sb.regwen_o !== 1'b0) begin errors++; $display("FAIL fl_regwen cyc %0d got %b want 0", c, sb.regwen_o); end
        checks++; if (sb.busy_o !== 32'h0) begin errors++; $display("FAIL fl_busy cyc %0d got %h want 0", c, sb.busy_o); end
        checks++; if (sb.inflight_o !== 2'd0) begin errors++; $display("FAIL fl_inflight cyc %0d got %0d want 0", c, sb.inflight_o); end
        checks++; if (sb.wb_addr_o !== 5'd3) begin errors++; $display("FAIL fl_addr_hold cyc %0d got %0d want 3", c, sb.wb_addr_o); end
      end
      tick();
    end
  endtask

  task automatic test_same_reg();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c == 0) issue(5'd5, 1'b1, 5'd5, 1'b1);
      if (c == 3) issue(5'd5, 1'b1, 5'd0, 1'b0);
      @(negedge clk);
      if (c == 0 || c == 3) begin
        checks++; if (sb.issue_ready_o !== 1'b1) begin errors++; $display("FAIL same_ready cyc %0d got %b want 1", c, sb.issue_ready_o); end
      end
      checks++; if (sb.regwen_o !== (c == 3 || c == 6)) begin errors++; $display("FAIL same_regwen cyc %0d got %b want %b", c, sb.regwen_o, c == 3 || c == 6); end
      checks++; if (sb.busy_o[5] !== (c >= 1 && c <= 6)) begin errors++; $display("FAIL same_busy5 cyc %0d got %b want %b", c, sb.busy_o[5], c >= 1 && c <= 6); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic       exp_v  [100];
    logic [4:0] exp_rd [100];
    logic [4:0] rd;
    logic       we;
    do_reset();
    for (int c = 0; c < 103; c++) begin
      if (c < 100) begin
        rd = 5'($urandom_range(0, 31));
        we = ($urandom_range(0, 3) != 0);
        issue(rd, we, 5'd0, 1'b1);
        sb.issue_rs2_i = 5'($urandom_range(0, 31));
        exp_v[c]  = we && (rd != 5'd0);
        exp_rd[c] = rd;
      end else begin
        idle();
      end
      @(negedge clk);
      if (c < 100) begin
        checks++; if (sb.stall_o !== 1'b0) begin errors++; $display("FAIL b2b_stall cyc %0d got %b want 0", c, sb.stall_o); end
      end
      if (c >= 3) begin
        checks++; if (sb.regwen_o !== exp_v[c-3]) begin errors++; $display("FAIL b2b_regwen cyc %0d got %b want %b", c, sb.regwen_o, exp_v[c-3]); end
        if (exp_v[c-3]) begin
          checks++; if (sb.wb_addr_o !== exp_rd[c-3]) begin errors++; $display("FAIL b2b_addr cyc %0d got %0d want %0d", c, sb.wb_addr_o, exp_rd[c-3]); end
        end
      end
      tick();
    end
    checks++; if (sb.stall_cnt_o !== 32'd0) begin errors++; $display("FAIL b2b_stallcnt got %0d want 0", sb.stall_cnt_o); end
    checks++; if (sb.inflight_o !== 2'd0) begin errors++; $display("FAIL b2b_drained got %0d want 0", sb.inflight_o); end
  endtask

  initial begin
    idle();
    test_reset();
    test_raw();
    test_x0();
    test_overlap();
    test_flush();
    test_same_reg();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
